// File: rtl/gpr_wb_sched.sv
// Writeback scheduler for the 8 x 16-bit GPR file: round-robin arbitration of the
// ALU/LSU writebacks onto the single GPR write port, plus a busy scoreboard for hazard stalls.
module gpr_wb_sched #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alu_wb_valid,
  input  logic [ADDR_W-1:0]   alu_wb_dest,
  input  logic [DATA_W-1:0]   alu_wb_data,
  output logic                alu_wb_ready,
  input  logic                lsu_wb_valid,
  input  logic [ADDR_W-1:0]   lsu_wb_dest,
  input  logic [DATA_W-1:0]   lsu_wb_data,
  output logic                lsu_wb_ready,
  input  logic                issue_valid,
  input  logic                issue_has_dest,
  input  logic [ADDR_W-1:0]   issue_dest,
  input  logic [ADDR_W-1:0]   issue_src_1,
  input  logic [ADDR_W-1:0]   issue_src_2,
  output logic                issue_stall,
  output logic                reg_write_en,
  output logic [ADDR_W-1:0]   reg_write_dest,
  output logic [DATA_W-1:0]   reg_write_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                sb_err
);

  // 1 = ALU was granted most recently; reset to LSU so the ALU wins first contention
  logic                last_grant_alu;
  logic                grant_alu;
  logic                grant_lsu;
  logic                wb_fire;
  logic [ADDR_W-1:0]   wb_dest;
  logic [DATA_W-1:0]   wb_data;
  logic                issue_accept;
  logic [NUM_REGS-1:0] busy_nxt;

  always_comb begin
    grant_alu = alu_wb_valid & (~lsu_wb_valid | ~last_grant_alu);
    grant_lsu = lsu_wb_valid & ~grant_alu;
    wb_fire   = grant_alu | grant_lsu;
    wb_dest   = grant_alu ? alu_wb_dest : lsu_wb_dest;
    wb_data   = grant_alu ? alu_wb_data : lsu_wb_data;
  end

  assign alu_wb_ready = grant_alu;
  assign lsu_wb_ready = grant_lsu;

  // Stall uses registered busy only: a writeback granted this cycle does not bypass
  assign issue_stall  = issue_valid & (busy_mask[issue_src_1] | busy_mask[issue_src_2] |
                                       (issue_has_dest & busy_mask[issue_dest]));
  assign issue_accept = issue_valid & ~issue_stall & issue_has_dest;

  // Set after clear so a new producer keeps ownership of the register
  always_comb begin
    busy_nxt = busy_mask;
    if (wb_fire) busy_nxt[wb_dest] = 1'b0;
    if (issue_accept) busy_nxt[issue_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_alu <= 1'b0;
      reg_write_en   <= 1'b0;
      reg_write_dest <= '0;
      reg_write_data <= '0;
      busy_mask      <= '0;
      sb_err         <= 1'b0;
    end else begin
      reg_write_en <= wb_fire;
      busy_mask    <= busy_nxt;
      if (wb_fire) begin
        last_grant_alu <= grant_alu;
        reg_write_dest <= wb_dest;
        reg_write_data <= wb_data;
        if (!busy_mask[wb_dest]) sb_err <= 1'b1;
      end
    end
  end

endmodule
